// File: rtl/nf10_sram_fifo_pkg.sv
// nf10_sram_fifo_pkg: shared AXIS widths, arbiter state encoding and round-robin search
package nf10_sram_fifo_pkg;

    localparam int AXIS_DATA_WIDTH = 256;
    localparam int AXIS_STRB_WIDTH = AXIS_DATA_WIDTH / 8;
    localparam int AXIS_USER_WIDTH = 128;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} arb_state_t;

    // First requester found searching cyclically from last+1; n is the live port count (<= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
        logic [2:0] pick;
        logic found;
        int idx;
        pick = last;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = (int'(last) + i) % n;
            if (i <= n && !found && req[3'(idx)]) begin
                pick = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/nf10_axis_skid_buf.sv
// nf10_axis_skid_buf: 2-entry registered AXIS pipeline; ready depends only on registered state
module nf10_axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             s_fire;

    assign s_ready = !skid_valid;
    assign s_fire  = s_valid && s_ready;

    // The skid slot only fills while the output register is stalled, so it drains first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!m_valid || m_ready) begin
            m_valid    <= skid_valid || s_fire;
            m_data     <= skid_valid ? skid_data : (s_fire ? s_data : m_data);
            skid_valid <= 1'b0;
        end else if (s_fire) begin
            skid_data  <= s_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/nf10_sram_fifo_in_arbiter.sv
// nf10_sram_fifo_in_arbiter: packet-granular round-robin arbiter feeding the SRAM FIFO write port
module nf10_sram_fifo_in_arbiter
    import nf10_sram_fifo_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int C_DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int C_USER_WIDTH = AXIS_USER_WIDTH,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [NUM_PORTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_PORTS*C_USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_PORTS-1:0]              s_axis_tlast,
    input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
    output logic [NUM_PORTS-1:0]              s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]         m_axis_tstrb,
    output logic [C_USER_WIDTH-1:0]           m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic [NUM_PORTS-1:0]              port_enable,
    output logic [$clog2(NUM_PORTS)-1:0]      grant_idx,
    output logic                              busy,
    output logic [NUM_PORTS*CNT_WIDTH-1:0]    pkt_count
);

    localparam int GW = $clog2(NUM_PORTS);
    localparam int SW = C_DATA_WIDTH / 8;
    localparam int BW = C_DATA_WIDTH + SW + C_USER_WIDTH + 1;

    arb_state_t           state;
    logic [NUM_PORTS-1:0] req;
    logic [GW-1:0]        pick;
    logic [CNT_WIDTH-1:0] cnt [NUM_PORTS];
    logic [BW-1:0]        s_beat;
    logic [BW-1:0]        m_beat;
    logic                 s_valid;
    logic                 s_ready;
    logic                 accept;

    assign req     = s_axis_tvalid & port_enable;
    assign pick    = GW'(rr_pick(8'(req), 3'(grant_idx), NUM_PORTS));
    assign busy    = (state == XFER);
    assign s_valid = busy && s_axis_tvalid[grant_idx];
    assign accept  = s_valid && s_ready;
    assign s_axis_tready = (busy && s_ready) ? NUM_PORTS'(1) << grant_idx : '0;
    assign s_beat = {s_axis_tlast[grant_idx],
                     s_axis_tuser[grant_idx*C_USER_WIDTH +: C_USER_WIDTH],
                     s_axis_tstrb[grant_idx*SW +: SW],
                     s_axis_tdata[grant_idx*C_DATA_WIDTH +: C_DATA_WIDTH]};
    assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = m_beat;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
        assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end

    // Grant is held for the whole packet; only an accepted tlast releases it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            grant_idx <= GW'(NUM_PORTS - 1);
            for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                grant_idx <= pick;
                state     <= XFER;
            end
        end else if (accept && s_axis_tlast[grant_idx]) begin
            cnt[grant_idx] <= cnt[grant_idx] + 1'b1;
            state          <= IDLE;
        end
    end

    nf10_axis_skid_buf #(.WIDTH(BW)) u_skid (
        .clk     (aclk),
        .rst     (areset),
        .s_data  (s_beat),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_beat),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

endmodule
